// File: rtl/psw_unit.sv
// Processor status word with condition flags, direct load, and a LIFO stack of
// saved PSWs for prioritised exception entry/return.
module psw_unit #(
    parameter int WORD  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] res,
    input  logic            cout,
    input  logic            ovf,
    input  logic [3:0]      flag_we,
    input  logic            chain,
    input  logic            psw_wr,
    input  logic [WORD-1:0] psw_din,
    input  logic            exc_req,
    input  logic [2:0]      exc_prio,
    input  logic            exc_ret,
    output logic [WORD-1:0] psw,
    output logic            c_flag,
    output logic            exc_ack,
    output logic            stk_err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Implemented bits: flags/SLP/CPRI in [7:0], PPRI in the top three bits.
    localparam logic [WORD-1:0] MASK =
        ({{(WORD-3){1'b0}}, 3'b111} << (WORD - 3)) | WORD'(8'hFF);

    logic [WORD-1:0] psw_q, psw_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            push;
    logic [WORD-1:0] stk_q [DEPTH];

    logic [2:0] cpri;
    logic       prio_hi, full, empty, accept;
    logic       z_new;

    assign cpri    = psw_q[7:5];
    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign prio_hi = exc_req && (exc_prio > cpri);
    assign accept  = prio_hi && !full;
    // In a carry-chained op the zero flag only survives if every word was zero.
    assign z_new   = (res == '0) && (!chain || psw_q[1]);

    always_comb begin
        psw_d   = psw_q;
        depth_d = depth_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        if (prio_hi && full) begin
            err_d = 1'b1;
        end
        if (accept) begin
            push                    = 1'b1;
            psw_d[WORD-1:WORD-3]    = cpri;
            psw_d[7:5]              = exc_prio;
            psw_d[3]                = 1'b0;
            depth_d                 = depth_q + DW'(1);
            ack_d                   = 1'b1;
        end else if (exc_ret) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                psw_d   = stk_q[AW'(depth_q - DW'(1))];
                depth_d = depth_q - DW'(1);
            end
        end else if (psw_wr) begin
            psw_d = psw_din & MASK;
        end else begin
            if (flag_we[0]) psw_d[0] = cout;
            if (flag_we[1]) psw_d[1] = z_new;
            if (flag_we[2]) psw_d[2] = res[WORD-1];
            if (flag_we[3]) psw_d[4] = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psw_q   <= '0;
            depth_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            psw_q   <= psw_d;
            depth_q <= depth_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Stack storage carries no reset; only the depth counter defines validity.
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            stk_q[AW'(depth_q)] <= psw_q;
        end
    end

    assign psw     = psw_q;
    assign c_flag  = psw_q[0];
    assign exc_ack = ack_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_psw_unit.sv
// Bench for psw_unit: directed literal scenarios followed by random traffic,
// all compared each cycle against a field-level behavioural model.
module tb_psw_unit;

    localparam int WORD  = 16;
    localparam int DEPTH = 4;

    logic            clk = 0;
    logic            rst_n;
    logic [WORD-1:0] res;
    logic            cout, ovf, chain, psw_wr, exc_req, exc_ret;
    logic [3:0]      flag_we;
    logic [WORD-1:0] psw_din;
    logic [2:0]      exc_prio;
    logic [WORD-1:0] psw;
    logic            c_flag, exc_ack, stk_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    psw_unit #(.WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .res(res), .cout(cout), .ovf(ovf),
        .flag_we(flag_we), .chain(chain), .psw_wr(psw_wr), .psw_din(psw_din),
        .exc_req(exc_req), .exc_prio(exc_prio), .exc_ret(exc_ret),
        .psw(psw), .c_flag(c_flag), .exc_ack(exc_ack), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: individual fields plus a queue of saved words.
    int mC, mZ, mN, mS, mV, mcpri, mppri;
    int mack, merr;
    logic [WORD-1:0] mstk[$];

    function automatic logic [WORD-1:0] pack();
        return WORD'(mC + 2*mZ + 4*mN + 8*mS + 16*mV + 32*mcpri + 8192*mppri);
    endfunction

    task automatic unpack(input logic [WORD-1:0] w);
        mC = w[0]; mZ = w[1]; mN = w[2]; mS = w[3]; mV = w[4];
        mcpri = w[7:5]; mppri = w[15:13];
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            unpack('0);
            mstk.delete();
            mack = 0;
            merr = 0;
        end else begin
            bit hi;
            mack = 0;
            hi = exc_req && (int'(exc_prio) > mcpri);
            if (hi && mstk.size() == DEPTH) merr = 1;
            if (hi && mstk.size() < DEPTH) begin
                mstk.push_back(pack());
                mppri = mcpri;
                mcpri = exc_prio;
                mS = 0;
                mack = 1;
            end else if (exc_ret) begin
                if (mstk.size() == 0) merr = 1;
                else unpack(mstk.pop_back());
            end else if (psw_wr) begin
                unpack(psw_din);
            end else begin
                if (flag_we[0]) mC = cout;
                if (flag_we[1]) mZ = ((res == 0) && (!chain || mZ == 1)) ? 1 : 0;
                if (flag_we[2]) mN = res[WORD-1];
                if (flag_we[3]) mV = ovf;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_psw", 32'(psw), 32'(pack()));
            chk("model_c_flag", 32'(c_flag), 32'(mC));
            chk("model_exc_ack", 32'(exc_ack), 32'(mack));
            chk("model_stk_err", 32'(stk_err), 32'(merr));
        end
    end

    task automatic idle();
        res = '0; cout = 0; ovf = 0; flag_we = '0; chain = 0;
        psw_wr = 0; psw_din = '0; exc_req = 0; exc_prio = '0; exc_ret = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [WORD-1:0] p, input logic a,
                       input logic e);
        chk({name, "_psw"}, 32'(psw), 32'(p));
        chk({name, "_ack"}, 32'(exc_ack), 32'(a));
        chk({name, "_err"}, 32'(stk_err), 32'(e));
    endtask

    initial begin
        idle();
        rst_n = 0;
        cyc();
        cyc();
        chk_en = 1;
        lit("reset", 16'h0000, 0, 0);
        chk("reset_c_flag", 32'(c_flag), 32'd0);
        rst_n = 1;

        res = '0; cout = 1; ovf = 0; flag_we = 4'hF; chain = 0;
        cyc();
        lit("flags_all", 16'h0003, 0, 0);
        chk("flags_c_flag", 32'(c_flag), 32'd1);

        res = 16'h0001; chain = 1; flag_we = 4'h2;
        cyc();
        lit("chain_nz", 16'h0001, 0, 0);
        res = 16'h0000;
        cyc();
        lit("chain_sticky", 16'h0001, 0, 0);

        idle(); psw_wr = 1; psw_din = 16'h1F40;
        cyc();
        lit("psw_wr_mask", 16'h0040, 0, 0);
        idle(); exc_req = 1; exc_prio = 3'd5;
        cyc();
        lit("entry", 16'h40A0, 1, 0);
        idle(); exc_ret = 1;
        cyc();
        lit("return", 16'h0040, 0, 0);

        idle(); psw_wr = 1; psw_din = 16'h00A8;
        cyc();
        idle(); exc_req = 1; exc_prio = 3'd3;
        cyc();
        lit("low_prio", 16'h00A8, 0, 0);

        idle(); psw_wr = 1; psw_din = 16'h0000;
        cyc();
        for (int p = 1; p <= 4; p++) begin
            idle(); exc_req = 1; exc_prio = 3'(p);
            cyc();
        end
        lit("nest4", 16'h6080, 1, 0);
        idle(); exc_req = 1; exc_prio = 3'd5;
        cyc();
        lit("nest_ovf", 16'h6080, 0, 1);

        idle(); exc_req = 1; exc_prio = 3'd7; rst_n = 0;
        cyc();
        lit("mid_reset", 16'h0000, 0, 0);
        chk("mid_reset_c", 32'(c_flag), 32'd0);
        idle(); rst_n = 1; exc_ret = 1;
        cyc();
        lit("ret_empty", 16'h0000, 0, 1);

        idle(); exc_req = 1; exc_prio = 3'd3; psw_wr = 1; psw_din = 16'hFFFF;
        flag_we = 4'hF; cout = 1; ovf = 1; res = 16'h8000;
        cyc();
        lit("simul", 16'h0060, 1, 1);

        idle(); rst_n = 0;
        cyc();
        rst_n = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            exc_req  = ($urandom_range(0, 3) == 0);
            exc_prio = 3'($urandom);
            exc_ret  = ($urandom_range(0, 4) == 0);
            psw_wr   = ($urandom_range(0, 11) == 0);
            psw_din  = WORD'($urandom);
            flag_we  = 4'($urandom);
            chain    = 1'($urandom);
            cout     = 1'($urandom);
            ovf      = 1'($urandom);
            res      = ($urandom_range(0, 2) == 0) ? '0 : WORD'($urandom);
            cyc();
        end
        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psw_unit.md
PSW_UNIT -- requirements
Module: psw_unit

Interface
REQ-001 Parameter WORD, default 16, datapath width; SHALL be at least 8.
REQ-002 Parameter DEPTH, default 4, number of saved-PSW entries in the exception stack.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 res  in  WORD  result from the arithmetic unit.
REQ-006 cout  in  1  carry out from the arithmetic unit.
REQ-007 ovf  in  1  overflow from the arithmetic unit.
REQ-008 flag_we  in  4  per-flag update mask: [3]=V, [2]=N, [1]=Z, [0]=C.
REQ-009 chain  in  1  high when the current op used carry-in (ADDC/SUBC); makes Z sticky.
REQ-010 psw_wr  in  1  direct PSW load strobe.
REQ-011 psw_din  in  WORD  direct PSW load value.
REQ-012 exc_req  in  1  exception entry request.
REQ-013 exc_prio  in  3  priority of the requesting exception.
REQ-014 exc_ret  in  1  return-from-exception strobe.
REQ-015 psw  out  WORD  registered PSW.
REQ-016 c_flag  out  1  registered C, fed to the arithmetic unit carry input.
REQ-017 exc_ack  out  1  one-cycle pulse: entry accepted.
REQ-018 stk_err  out  1  sticky stack fault (overflow or underflow).

Function
REQ-019 PSW layout SHALL be: bit0 C, bit1 Z, bit2 N, bit3 SLP, bit4 V, bits7:5 current priority (CPRI), bits WORD-1:WORD-3 previous priority (PPRI); all other bits SHALL read 0.
REQ-020 Flag update: a flag SHALL load only when its flag_we bit is 1; flags with mask bit 0 SHALL hold.
REQ-021 New values: C=cout, V=ovf, N=res[WORD-1], Z=(res==0) when chain=0, Z=Z_old AND (res==0) when chain=1.
REQ-022 Latency: flag, psw and c_flag changes SHALL be visible one cycle after the inputs are sampled.
REQ-023 psw_wr SHALL load psw_din with reserved bits forced to 0; it SHALL not touch the stack.
REQ-024 Exception entry is accepted only when exc_req=1, exc_prio > CPRI, and the stack is not full.
REQ-025 On acceptance: push the current PSW, set PPRI=CPRI, set CPRI=exc_prio, clear SLP, leave C/Z/N/V unchanged, and pulse exc_ack for 1 cycle.
REQ-026 Entry with exc_prio <= CPRI SHALL be ignored: no state change, no ack, no error.
REQ-027 Entry while the stack holds DEPTH entries SHALL set stk_err, not push, and not ack.
REQ-028 exc_ret with a non-empty stack SHALL pop the top entry into the PSW wholesale.
REQ-029 exc_ret with an empty stack SHALL set stk_err and leave the PSW unchanged.
REQ-030 The stack SHALL be LIFO, with a depth counter ranging 0..DEPTH and no wrap-around.
REQ-031 Simultaneous events, highest priority first: accepted exc_req, exc_ret, psw_wr, flag update. Only the highest-priority event SHALL take effect in a cycle; lower ones are dropped.
REQ-032 A rejected exc_req (REQ-026/027) SHALL not block lower-priority events in the same cycle.
REQ-033 stk_err SHALL clear only on reset.

Reset
REQ-034 While rst_n=0 at a clock edge: psw=0, c_flag=0, exc_ack=0, stk_err=0, stack depth=0; stack contents are don't-care.
REQ-035 Reset SHALL override every simultaneous event, including one mid-exception; the stack SHALL be empty afterwards.

Verification
REQ-036 After reset, res=0, cout=1, ovf=0, flag_we=4'hF, chain=0 -> next cycle psw=16'h0003, c_flag=1.
REQ-037 With Z=1 set, chain=1, res=16'h0001, flag_we=4'h2 -> Z=0; repeat with res=0 and Z=0 -> Z stays 0.
REQ-038 With CPRI=2, exc_req with prio 5 -> exc_ack pulse, psw[7:5]=5, psw[15:13]=2; then exc_ret -> psw restored bit-exact.
REQ-039 With CPRI=5, exc_req with prio 3 -> no ack, psw unchanged; five accepted nested entries with DEPTH=4 -> fifth sets stk_err, depth stays 4.
REQ-040 exc_ret on an empty stack -> stk_err=1, psw unchanged; in the same cycle exc_req(accepted) plus psw_wr plus flag_we=4'hF -> only the entry takes effect.
REQ-041 Assert rst_n=0 with depth=2 and exc_req=1 -> next cycle every output is 0 and a following exc_ret sets stk_err.
